// File: rtl/lc3_mem_seq.sv
// LC-3 memory-access sequencer: owns MAR/MDR/WDR and walks the memory port
// through direct and indirect reads/writes with a ready handshake and an
// optional per-phase timeout.
module lc3_mem_seq #(
   parameter int DW      = 16,
   parameter int AW      = 16,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [1:0]    req_op,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_re,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_rdy
);

   localparam int CW_RAW = $clog2(TIMEOUT + 1);
   localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
   localparam bit TO_EN  = (TIMEOUT != 0);
   localparam logic [CW-1:0] WCNT_LAST = TO_EN ? CW'(TIMEOUT - 1) : '0;

   localparam logic [1:0] OP_WRITE = 2'b01;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_WR   = 3'd2,
      S_PTR  = 3'd3,
      S_RSP  = 3'd4
   } state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] mar_q,   mar_d;
   logic [DW-1:0] mdr_q,   mdr_d;
   logic [DW-1:0] wdr_q,   wdr_d;
   logic [1:0]    op_q,    op_d;
   logic          ind_q,   ind_d;
   logic [CW-1:0] wcnt_q,  wcnt_d;
   logic          err_q,   err_d;

   logic [AW-1:0] ptr_s;
   logic          expire_s;

   // Pointer fetched by the first indirect phase (truncated or zero-extended to AW)
   always_comb begin
      ptr_s = AW'(mdr_q);
   end

   // Phase timeout: last allowed wait cycle passes without the memory completing
   always_comb begin
      expire_s = 1'b0;
      if (TO_EN && (wcnt_q == WCNT_LAST) && !mem_rdy) begin
         expire_s = 1'b1;
      end else begin
         expire_s = 1'b0;
      end
   end

   // Next-state and register-update logic for the sequencer
   always_comb begin
      state_d = state_q;
      mar_d   = mar_q;
      mdr_d   = mdr_q;
      wdr_d   = wdr_q;
      op_d    = op_q;
      ind_d   = ind_q;
      wcnt_d  = wcnt_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               mar_d  = req_addr;
               wdr_d  = req_wdata;
               op_d   = req_op;
               ind_d  = req_op[1];
               wcnt_d = '0;
               if (req_op == OP_WRITE) begin
                  state_d = S_WR;
               end else begin
                  state_d = S_RD;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RD: begin
            if (mem_rdy) begin
               mdr_d = mem_rdata;
               if (ind_q) begin
                  state_d = S_PTR;
               end else begin
                  state_d = S_RSP;
               end
            end else begin
               wcnt_d = wcnt_q + CW'(1);
               if (expire_s) begin
                  err_d   = 1'b1;
                  state_d = S_RSP;
               end else begin
                  state_d = S_RD;
               end
            end
         end
         S_WR: begin
            if (mem_rdy) begin
               state_d = S_RSP;
            end else begin
               wcnt_d = wcnt_q + CW'(1);
               if (expire_s) begin
                  err_d   = 1'b1;
                  state_d = S_RSP;
               end else begin
                  state_d = S_WR;
               end
            end
         end
         S_PTR: begin
            mar_d  = ptr_s;
            ind_d  = 1'b0;
            wcnt_d = '0;
            if (op_q[0]) begin
               state_d = S_WR;
            end else begin
               state_d = S_RD;
            end
         end
         S_RSP: begin
            err_d   = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         mar_q   <= '0;
         mdr_q   <= '0;
         wdr_q   <= '0;
         op_q    <= 2'b00;
         ind_q   <= 1'b0;
         wcnt_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mar_q   <= mar_d;
         mdr_q   <= mdr_d;
         wdr_q   <= wdr_d;
         op_q    <= op_d;
         ind_q   <= ind_d;
         wcnt_q  <= wcnt_d;
         err_q   <= err_d;
      end
   end

   // Output decode straight from registered state; read data only for clean reads
   always_comb begin
      req_ready = (state_q == S_IDLE) && rst;
      mem_re    = (state_q == S_RD);
      mem_we    = (state_q == S_WR);
      mem_addr  = mar_q;
      mem_wdata = wdr_q;
      rsp_valid = (state_q == S_RSP);
      rsp_err   = (state_q == S_RSP) && err_q;
      if ((state_q == S_RSP) && !op_q[0] && !err_q) begin
         rsp_rdata = mdr_q;
      end else begin
         rsp_rdata = '0;
      end
   end

endmodule

// File: tb/tb_lc3_mem_seq.sv
// Self-checking bench for lc3_mem_seq: transaction-level reference model plus
// a reactive memory with programmable wait states.
module tb_lc3_mem_seq;

   localparam int TO = 4;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_err;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_re;
   logic        mem_we;
   logic [15:0] mem_rdata;
   logic        mem_rdy;

   logic [15:0] mem [0:65535];

   int n_cmp;
   int n_fail;

   lc3_mem_seq #(.DW(16), .AW(16), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_re    (mem_re),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata),
      .mem_rdy   (mem_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".req_ready"}, 32'(req_ready), 32'd0);
      check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, ".rsp_rdata"}, 32'(rsp_rdata), 32'd0);
      check({tag, ".rsp_err"},   32'(rsp_err),   32'd0);
      check({tag, ".mem_addr"},  32'(mem_addr),  32'd0);
      check({tag, ".mem_wdata"}, 32'(mem_wdata), 32'd0);
      check({tag, ".mem_re"},    32'(mem_re),    32'd0);
      check({tag, ".mem_we"},    32'(mem_we),    32'd0);
   endtask

   // One complete transaction: reference expectations first, then cycle-by-cycle
   // memory responses and observation. w1/w2 = wait cycles in phase 1/2
   // (w >= TO means the memory never answers in that phase).
   task automatic run_txn(input string tag, input logic [1:0] op, input logic [15:0] addr,
                          input logic [15:0] wdata, input int w1, input int w2);
      logic [15:0] ptr;
      logic [15:0] exp_rd;
      logic [15:0] pa [2];
      logic        pw [2];
      int          wt [2];
      bit          ind, ok1, ok2, exp_err, in_ph, got;
      int          cyc1, cyc2, lat, nph_exp, ph, cnt, bound;

      ind  = op[1];
      ptr  = mem[addr];
      ok1  = (w1 < TO);
      cyc1 = ok1 ? w1 + 1 : TO;
      if (ind && ok1) begin
         ok2  = (w2 < TO);
         cyc2 = ok2 ? w2 + 1 : TO;
      end else begin
         ok2  = 1'b1;
         cyc2 = 0;
      end
      exp_err = !ok1 || !ok2;
      lat     = 1 + cyc1 + ((ind && ok1) ? 1 + cyc2 : 0);
      nph_exp = (ind && ok1) ? 2 : 1;
      if (exp_err || op[0]) exp_rd = 16'h0000;
      else if (ind)         exp_rd = mem[ptr];
      else                  exp_rd = mem[addr];
      pa[0] = addr;
      pa[1] = ptr;
      pw[0] = (op == 2'b01);
      pw[1] = op[0];
      wt[0] = w1;
      wt[1] = w2;

      bound = 0;
      while (!req_ready && bound < 20) begin
         @(negedge clk);
         bound++;
      end
      check({tag, ".ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wdata;
      mem_rdy   = 1'b0;
      @(posedge clk);

      ph = 0; in_ph = 1'b0; cnt = 0; got = 1'b0;
      for (int c = 1; c <= lat + 2; c++) begin
         @(negedge clk);
         if (c < lat) begin
            req_valid = 1'($urandom_range(0, 1));
            req_op    = 2'($urandom);
            req_addr  = 16'($urandom);
            req_wdata = 16'($urandom);
         end else begin
            req_valid = 1'b0;
         end
         check({tag, ".excl"}, 32'(mem_re && mem_we), 32'd0);
         if (mem_re || mem_we) begin
            if (!in_ph) begin
               ph++;
               in_ph = 1'b1;
               cnt   = 0;
            end
            if (ph <= 2) begin
               check({tag, ".addr"}, 32'(mem_addr), 32'(pa[ph-1]));
               check({tag, ".we"},   32'(mem_we),   32'(pw[ph-1]));
               if (mem_we) check({tag, ".wdata"}, 32'(mem_wdata), 32'(wdata));
               if (cnt == wt[ph-1]) begin
                  mem_rdy = 1'b1;
                  if (mem_we) mem[mem_addr] = mem_wdata;
                  else        mem_rdata = mem[mem_addr];
               end else begin
                  mem_rdy   = 1'b0;
                  mem_rdata = 16'($urandom);
               end
            end else begin
               mem_rdy = 1'b1;
            end
            cnt++;
         end else begin
            in_ph     = 1'b0;
            mem_rdy   = 1'($urandom_range(0, 1));
            mem_rdata = 16'($urandom);
         end
         if (rsp_valid) begin
            got = 1'b1;
            check({tag, ".lat"},   32'(c),         32'(lat));
            check({tag, ".rdata"}, 32'(rsp_rdata), 32'(exp_rd));
            check({tag, ".err"},   32'(rsp_err),   32'(exp_err));
         end
      end
      mem_rdy = 1'b0;
      check({tag, ".rsp_seen"}, 32'(got), 32'd1);
      check({tag, ".phases"},   32'(ph),  32'(nph_exp));
   endtask

   initial begin
      n_cmp     = 0;
      n_fail    = 0;
      rst       = 1'b0;
      req_valid = 1'b0;
      req_op    = 2'b00;
      req_addr  = 16'h0000;
      req_wdata = 16'h0000;
      mem_rdata = 16'h0000;
      mem_rdy   = 1'b0;
      for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
      mem[16'h3000] = 16'h1234;
      mem[16'h3001] = 16'h5000;
      mem[16'h5000] = 16'h00AA;
      mem[16'h3002] = 16'h6000;

      // Reset state
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b1;
      @(negedge clk);
      check("post_reset.ready", 32'(req_ready), 32'd1);

      // Directed cases
      run_txn("rd_3000",     2'b00, 16'h3000, 16'h0000, 0, 0);
      run_txn("wr_4000",     2'b01, 16'h4000, 16'hBEEF, 3, 0);
      run_txn("ird_3001",    2'b10, 16'h3001, 16'h0000, 0, 0);
      run_txn("iwr_3002",    2'b11, 16'h3002, 16'h7777, 0, 0);
      run_txn("rd_6000",     2'b00, 16'h6000, 16'h0000, 1, 0);
      run_txn("rd_4000",     2'b00, 16'h4000, 16'h0000, 2, 0);
      run_txn("rd_timeout",  2'b00, 16'h3000, 16'h0000, 100, 0);
      run_txn("rd_last_rdy", 2'b00, 16'h3000, 16'h0000, TO - 1, 0);
      run_txn("wr_timeout",  2'b01, 16'h4100, 16'h1111, 100, 0);
      run_txn("ird_to_ph2",  2'b10, 16'h3001, 16'h0000, 1, 100);
      run_txn("iwr_to_ph1",  2'b11, 16'h3002, 16'h2222, 100, 0);

      // Randomized cases
      for (int k = 0; k < 40; k++) begin
         run_txn("rand", 2'($urandom), 16'($urandom), 16'($urandom),
                 $urandom_range(0, TO), $urandom_range(0, TO));
      end

      // Reset in the middle of a write phase
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = 2'b01;
      req_addr  = 16'h4200;
      req_wdata = 16'h5A5A;
      mem_rdy   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("mid_rst.in_wr", 32'(mem_we), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("mid_rst");
      rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("mid_rst.ready", 32'(req_ready), 32'd1);
         check("mid_rst.no_rsp", 32'(rsp_valid), 32'd0);
      end
      run_txn("after_rst", 2'b00, 16'h3000, 16'h0000, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/lc3_mem_seq.md
# lc3_mem_seq

Parametrised memory-access sequencer: the next-generation MAR/MDR unit for the LC-3 datapath, split out of the control FSM. It accepts one request at a time from the core controller (read, write, indirect read, indirect write) and sequences the memory port through MAR/MDR registers. Unlike the fixed single-cycle memory assumption in the current datapath, it supports variable-latency memory through a `mem_rdy` handshake and a bounded timeout. Widths are parametrised.

## Interface
- `DW`, 16, data width (MDR, memory data).
- `AW`, 16, address width (MAR); an indirect pointer is `MDR[AW-1:0]`, zero-extended if `AW` > `DW`.
- `TIMEOUT`, 15, maximum wait cycles per memory phase; 0 disables timeout. Counter width is `$clog2(TIMEOUT+1)`, minimum 1.

Ports:
- `clk`  in  1  single clock; everything is updated on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block idle and able to accept; equals (state==IDLE) && `rst`.
- `req_op`  in  2  00 read, 01 write, 10 indirect read, 11 indirect write.
- `req_addr`  in  AW  direct address, or the pointer location for indirect operations.
- `req_wdata`  in  DW  store data; captured at accept.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  DW  read result; 0 for writes and on error.
- `rsp_err`  out  1  qualified by `rsp_valid`; timeout occurred.
- `mem_addr`  out  AW  MAR register.
- `mem_wdata`  out  DW  write-data register.
- `mem_re`  out  1  read strobe, held until `mem_rdy`.
- `mem_we`  out  1  write strobe, held until `mem_rdy`.
- `mem_rdata`  in  DW  read data; valid only when `mem_rdy` is 1.
- `mem_rdy`  in  1  memory completes the current read or write in this cycle.

## Operation
- Registers: MAR, MDR, WDR (write data), op, indirect flag `ind`, wait counter `wcnt`, error flag.
- State machine states: IDLE, RD, WR, PTR, RSP.
- **IDLE**
  - On `req_valid`: MAR<=`req_addr`, WDR<=`req_wdata`, op<=`req_op`, `ind`<=`req_op[1]`, `wcnt`<=0.
  - Next state: RD if `req_op` is read, indirect read or indirect write; WR if `req_op` is write.
- **RD**
  - `mem_re`=1.
  - On `mem_rdy`: MDR<=`mem_rdata`. If `ind`=1, go to PTR; otherwise go to RSP.
- **PTR**
  - MAR<=MDR[AW-1:0], `ind`<=0, `wcnt`<=0.
  - Next state: RD for indirect read, WR for indirect write.
  - No strobe is asserted in this state.
- **WR**
  - `mem_we`=1, `mem_wdata`=WDR.
  - On `mem_rdy`: go to RSP.
- **RSP**
  - `rsp_valid`=1.
  - `rsp_rdata`=MDR for a successful read or indirect read; 0 otherwise.
  - `rsp_err`=error flag.
  - Next state: IDLE. The error flag clears on that transition.
- **Timeout**
  - In RD or WR with `mem_rdy`=0, `wcnt` increments.
  - If `TIMEOUT`≠0 and `wcnt`==`TIMEOUT`-1 while `mem_rdy`=0: set the error flag and go to RSP. The indirect second phase is abandoned.
  - `mem_rdy` in the same cycle as the timeout wins: no error.
- `mem_re` and `mem_we` are never both 1.
- `mem_rdy` outside RD/WR is ignored.
- `req_valid` outside IDLE is ignored; no queueing.
- The write data returned for an indirect write is WDR, never the pointer.

## Timing
- Reset (`rst`=0 at a clock edge) sets:
  - state=IDLE;
  - MAR, MDR, WDR, `wcnt`, error flag = 0;
  - all outputs 0, including `req_ready`, which is 0 while `rst` is low.
- Reset mid-operation aborts immediately. No `rsp_valid` is produced, and the strobes drop in the cycle after the reset edge.
- Latency, with request accepted at edge T and zero-wait memory (`mem_rdy`=1):
  - read: `mem_re` high in cycle T+1, `rsp_valid` in cycle T+2;
  - write: `mem_we` high in cycle T+1, `rsp_valid` in cycle T+2;
  - indirect read: RD in T+1, PTR in T+2, RD in T+3, `rsp_valid` in T+4;
  - indirect write: same, with WR in T+3.
- Each wait cycle (`mem_rdy`=0) adds one cycle per phase.
- The earliest next accept is in the cycle after RSP, giving a throughput of one direct operation per 3 cycles.
- `mem_addr` is stable for the whole RD/WR phase.

## Test plan
- Read, addr 0x3000, memory returns 0x1234 with 0 waits -> `mem_re` for 1 cycle with `mem_addr`=0x3000; `rsp_valid` at T+2 with `rsp_rdata`=0x1234, `rsp_err`=0.
- Write 0xBEEF to 0x4000 with `mem_rdy` delayed 3 cycles -> `mem_we` held 4 cycles with `mem_wdata`=0xBEEF; `rsp_valid` at T+5, `rsp_rdata`=0.
- Indirect read: mem[0x3001]=0x5000, mem[0x5000]=0x00AA -> second `mem_addr`=0x5000; `rsp_rdata`=0x00AA at T+4.
- Indirect write of 0x7777 with pointer 0x6000 -> one read at the pointer address, then a write to 0x6000 with `mem_wdata`=0x7777; `rsp_valid` at T+4.
- TIMEOUT=4, `mem_rdy` held 0 -> `mem_re` high for 4 cycles; `rsp_valid` with `rsp_err`=1 and `rsp_rdata`=0. A `mem_rdy` arriving on the 4th cycle instead gives `rsp_err`=0.
- Reset asserted while in WR -> next cycle state IDLE with all outputs 0; after `rst`=1, `req_ready`=1 and no `rsp_valid` pulse is produced.
